uart_rx_buffer: RTL and testbench

Receive-side byte buffer that sits directly downstream of the UART receiver. It captures each byte the receiver completes, indicated by the rising edge of its `end_flag`, into a circular FIFO. The FIFO is presented to the Jacaranda-8 CPU's I/O logic in first-word-fall-through form, together with occupancy, a sticky overrun flag and a level interrupt request. The block decouples byte arrival from the CPU's software polling and interrupt latency.

---
 rtl/uart_rx_buffer_if.sv | 37 +++
 rtl/uart_rx_buffer.sv | 86 ++++++++
 tb/tb_uart_rx_buffer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_buffer_if.sv
// uart_rx_buffer_if: bundle between the UART receiver / CPU I/O logic and
// the receive byte buffer. slave = buffer side, master = driver side.
//   rx_data/rx_end    : byte and completion flag from the receiver
//   rd_en/rd_data     : FWFT pop request and head byte
//   empty/full/count  : occupancy status
//   overrun/_clr      : sticky dropped-byte flag and its clear
//   int_en/req/ack    : level interrupt enable, request, acknowledge
interface uart_rx_buffer_if #(
    parameter int AW = 4
);
    logic [7:0]  rx_data;
    logic        rx_end;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        empty;
    logic        full;
    logic [AW:0] count;
    logic        overrun;
    logic        overrun_clr;
    logic        int_en;
    logic        int_req;
    logic        int_ack;

    modport slave (
        input  rx_data, rx_end, rd_en,
        input  overrun_clr, int_en, int_ack,
        output rd_data, empty, full, count,
        output overrun, int_req
    );

    modport master (
        output rx_data, rx_end, rd_en,
        output overrun_clr, int_en, int_ack,
        input  rd_data, empty, full, count,
        input  overrun, int_req
    );
endinterface

// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: circular FWFT byte FIFO capturing each rising edge of the
// receiver's end flag, with occupancy, sticky overrun and level interrupt.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : uart_rx_buffer_if.slave (see interface file)
module uart_rx_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic            clk,
    input  logic            reset,
    uart_rx_buffer_if.slave bus
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          rx_end_dly_q, rx_end_dly_d;
    logic          overrun_q, overrun_d;
    logic          int_req_q, int_req_d;

    logic empty, full;
    logic push, pop_ok, push_ok;

    always_comb begin
        empty        = (cnt_q == '0);
        full         = (cnt_q == FULL_CNT);
        push         = bus.rx_end & ~rx_end_dly_q;
        pop_ok       = bus.rd_en & ~empty;
        // A pop in the same cycle frees the slot a full FIFO needs.
        push_ok      = push & (~full | pop_ok);
        rx_end_dly_d = bus.rx_end;
        wp_d         = wp_q;
        rp_d         = rp_q;
        cnt_d        = cnt_q;
        overrun_d    = overrun_q;
        int_req_d    = int_req_q;

        if (push_ok) wp_d = wp_q + 1'b1;
        if (pop_ok)  rp_d = rp_q + 1'b1;

        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        // Set has priority over clear for both sticky flags.
        if (push & ~push_ok)      overrun_d = 1'b1;
        else if (bus.overrun_clr) overrun_d = 1'b0;

        if (push_ok & bus.int_en) int_req_d = 1'b1;
        else if (bus.int_ack)     int_req_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q         <= '0;
            rp_q         <= '0;
            cnt_q        <= '0;
            rx_end_dly_q <= 1'b0;
            overrun_q    <= 1'b0;
            int_req_q    <= 1'b0;
        end else begin
            wp_q         <= wp_d;
            rp_q         <= rp_d;
            cnt_q        <= cnt_d;
            rx_end_dly_q <= rx_end_dly_d;
            overrun_q    <= overrun_d;
            int_req_q    <= int_req_d;
        end
    end

    // Storage is not reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok && !reset) mem_q[wp_q] <= bus.rx_data;
    end

    assign bus.rd_data = empty ? 8'h00 : mem_q[rp_q];
    assign bus.empty   = empty;
    assign bus.full    = full;
    assign bus.count   = cnt_q;
    assign bus.overrun = overrun_q;
    assign bus.int_req = int_req_q;
endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb_uart_rx_buffer: directed and randomized stimulus for uart_rx_buffer,
// compared every cycle against a queue-based reference model.
module tb_uart_rx_buffer;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   passed = 0;
    int   total = 0;

    uart_rx_buffer_if #(.AW(4)) bus ();

    uart_rx_buffer #(.DEPTH(DEPTH), .AW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: the FIFO is a plain queue of bytes.
    logic [7:0] mq[$];
    bit         m_prev;
    bit         m_ovr;
    bit         m_irq;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        if (obs !== exp)
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        else
            passed++;
    endtask

    task automatic check_all();
        check("count",   32'(bus.count),   32'(mq.size()));
        check("empty",   32'(bus.empty),   32'(mq.size() == 0));
        check("full",    32'(bus.full),    32'(mq.size() == DEPTH));
        check("rd_data", 32'(bus.rd_data), (mq.size() > 0) ? 32'(mq[0]) : 0);
        check("overrun", 32'(bus.overrun), 32'(m_ovr));
        check("int_req", 32'(bus.int_req), 32'(m_irq));
    endtask

    task automatic model(input bit e, input logic [7:0] d, input bit rd,
                         input bit clr, input bit ie, input bit ack,
                         input bit rst);
        bit push, pop, pok;
        if (rst) begin
            mq.delete();
            m_prev = 0;
            m_ovr  = 0;
            m_irq  = 0;
        end else begin
            push   = e && !m_prev;
            m_prev = e;
            pop    = rd && mq.size() > 0;
            pok    = push && (mq.size() < DEPTH || pop);
            if (pop) void'(mq.pop_front());
            if (pok) mq.push_back(d);
            if (push && !pok) m_ovr = 1;
            else if (clr)     m_ovr = 0;
            if (pok && ie)    m_irq = 1;
            else if (ack)     m_irq = 0;
        end
    endtask

    task automatic step(input bit e, input logic [7:0] d, input bit rd,
                        input bit clr = 0, input bit ie = 0,
                        input bit ack = 0, input bit rst = 0);
        bus.rx_end      = e;
        bus.rx_data     = d;
        bus.rd_en       = rd;
        bus.overrun_clr = clr;
        bus.int_en      = ie;
        bus.int_ack     = ack;
        reset           = rst;
        @(posedge clk);
        model(e, d, rd, clr, ie, ack, rst);
        @(negedge clk);
        check_all();
    endtask

    task automatic pulse(input logic [7:0] d, input bit ie = 0);
        step(1, d, 0, 0, ie);
        step(0, 8'h00, 0, 0, ie);
    endtask

    initial begin
        bus.rx_end = 0; bus.rx_data = 0; bus.rd_en = 0;
        bus.overrun_clr = 0; bus.int_en = 0; bus.int_ack = 0;

        // Reset state
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        check("rst_empty", 32'(bus.empty), 1);
        check("rst_count", 32'(bus.count), 0);
        check("rst_rdata", 32'(bus.rd_data), 0);
        step(0, 0, 0);

        // Three bytes in, three out in order
        pulse(8'h41); pulse(8'h42); pulse(8'h43);
        check("three_cnt", 32'(bus.count), 3);
        for (int i = 0; i < 3; i++) begin
            check("three_pop", 32'(bus.rd_data), 32'h41 + i);
            step(0, 0, 1);
        end
        check("three_empty", 32'(bus.empty), 1);
        check("three_zero", 32'(bus.rd_data), 0);

        // Held flag gives one push
        repeat (5) step(1, 8'h55, 0);
        step(0, 0, 0);
        check("held_cnt", 32'(bus.count), 1);
        step(0, 0, 1);

        // Overfill by one
        for (int i = 0; i < 17; i++) pulse(8'(i));
        check("ovf_full", 32'(bus.full), 1);
        check("ovf_cnt", 32'(bus.count), 16);
        check("ovf_flag", 32'(bus.overrun), 1);
        for (int i = 0; i < 16; i++) begin
            check("ovf_drain", 32'(bus.rd_data), 32'(i));
            step(0, 0, 1);
        end
        check("ovf_gone", 32'(bus.empty), 1);
        step(0, 0, 0, 1);
        check("ovf_clr", 32'(bus.overrun), 0);

        // Full with simultaneous push and pop
        for (int i = 0; i < 16; i++) pulse(8'(8'h20 + i));
        step(1, 8'hAA, 1);
        check("sim_cnt", 32'(bus.count), 16);
        check("sim_ovr", 32'(bus.overrun), 0);
        step(0, 0, 0);
        for (int i = 0; i < 15; i++) step(0, 0, 1);
        check("sim_last", 32'(bus.rd_data), 32'hAA);
        step(0, 0, 1);
        check("sim_empty", 32'(bus.empty), 1);

        // Randomized traffic across pointer wrap
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 8'($urandom),
                 $urandom_range(0, 9) < 4, $urandom_range(0, 19) == 0,
                 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
        repeat (DEPTH + 1) step(0, 0, 1);
        step(0, 0, 1);
        check("rd_empty_cnt", 32'(bus.count), 0);
        step(0, 0, 0, 1, 0, 1);

        // Interrupt behaviour
        pulse(8'h11, 1);
        check("irq_set", 32'(bus.int_req), 1);
        step(0, 0, 0, 0, 0, 1);
        check("irq_ack", 32'(bus.int_req), 0);
        step(1, 8'h12, 0, 0, 1, 1);
        check("irq_ack_set", 32'(bus.int_req), 1);
        step(0, 0, 0, 0, 0, 1);
        pulse(8'h13, 0); pulse(8'h14, 0);
        check("irq_dis", 32'(bus.int_req), 0);
        pulse(8'h15, 1);
        check("irq_pre_rst", 32'(bus.int_req), 1);
        step(0, 0, 0, 0, 0, 0, 1);
        check("rst_mid_cnt", 32'(bus.count), 0);
        check("rst_mid_irq", 32'(bus.int_req), 0);

        // Flag already high right after reset counts as an edge
        step(1, 8'h77, 0);
        check("post_rst_edge", 32'(bus.count), 1);
        step(0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
